// File: rtl/serial_add_8bit.sv
// Bit-serial adder: consumes two LSB-first operand streams, accumulates the sum
// into a parallel register and flags completion after WIDTH bits.
module serial_add_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             A,
    input  logic             B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic w_sum_bit;
    logic w_carry_nxt;
    logic w_last;

    // Full-adder slice for the bit currently on the serial inputs
    assign w_sum_bit   = A ^ B ^ r_carry;
    assign w_carry_nxt = (A & B) | (r_carry & (A ^ B));
    assign w_last      = (r_count == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; Start is only honoured outside ADD
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_nxt = S_ADD;
            S_ADD:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (Start) w_state_nxt = S_ADD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_carry <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_carry <= w_carry_nxt;
                    r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
                    if (w_last) begin
                        r_count <= '0;
                        r_cout  <= w_carry_nxt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule
